// File: rtl/vs_uart_pkg.sv
// Shared UART definitions for the transmit and receive sides.
//   state_t    : frame FSM state encoding
//   DATA_BITS  : payload bits per frame
//   FRAME_BITS : start + data + parity + stop
//   calc_div   : rounded clock cycles per bit
package vs_uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Nearest integer number of clock cycles per bit.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/vs_baud_gen.sv
// Bit-period counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   restart    : hold the counter at 0 (no phase carried into the next frame)
//   div        : bit period in clock cycles (>= 2)
//   tick       : one-cycle strobe in the last cycle of each bit period
module vs_baud_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign tick = !restart && (cnt == div - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/vs_uart_err_tx.sv
// UART transmitter with parity / framing error injection.
// Frame: start 0, 8 data bits LSB first, parity, stop; each bit DIV cycles.
//   CLK, SYS_NRST : clock, asynchronous active-low reset
//   TX_DATA       : byte to send, latched on acceptance
//   TX_VALID      : send request, accepted only while TX_RDY is high
//   INJ_PAR_ERR   : invert the parity bit of the accepted frame
//   INJ_FRM_ERR   : drive the stop bit of the accepted frame low
//   TX_RDY        : high in IDLE only
//   TX_DONE       : one-cycle pulse as the stop bit completes
//   TXD           : registered serial line, idles high
module vs_uart_err_tx
  import vs_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int PAR_ODD  = 0
) (
  input  logic                 CLK,
  input  logic                 SYS_NRST,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  input  logic                 INJ_PAR_ERR,
  input  logic                 INJ_FRM_ERR,
  output logic                 TX_RDY,
  output logic                 TX_DONE,
  output logic                 TXD
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  // +1 so that a power-of-two DIV still fits in the div port.
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  if (DIV < 2) begin : g_div_chk
    $error("vs_uart_err_tx: bit period DIV must be at least 2 clock cycles");
  end
  if (FRAME_BITS != DATA_BITS + 3) begin : g_frame_chk
    $error("vs_uart_err_tx: frame layout inconsistent with package");
  end

  state_t               state, state_nxt;
  logic                 accept, tick;
  logic [DATA_BITS-1:0] data_q;
  logic                 inj_par_q, inj_frm_q;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic                 txd_q, txd_nxt;
  logic                 done_q, done_nxt;

  assign TX_RDY  = (state == ST_IDLE);
  assign accept  = TX_VALID && TX_RDY;
  assign TXD     = txd_q;
  assign TX_DONE = done_q;

  // Counter is held at 0 throughout IDLE, so every frame starts phase-aligned
  // with its acceptance.
  vs_baud_gen #(
    .CNT_W (CNT_W)
  ) u_baud (
    .clk     (CLK),
    .rst_n   (SYS_NRST),
    .restart (TX_RDY),
    .div     (CNT_W'(DIV)),
    .tick    (tick)
  );

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        idx_nxt = '0;
        if (accept) state_nxt = ST_START;
      end
      ST_START: begin
        if (tick) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          idx_nxt = idx + IDX_ONE;  // wraps 7 -> 0 on the last data bit
          if (idx == IDX_LAST) state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (tick) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Line level is computed for the state being entered so that TXD can be
  // registered without adding a cycle of latency.
  always_comb begin
    txd_nxt  = 1'b1;
    done_nxt = (state == ST_STOP) && tick;
    case (state_nxt)
      ST_START:  txd_nxt = 1'b0;
      ST_DATA:   txd_nxt = data_q[idx_nxt];
      ST_PARITY: txd_nxt = (^data_q) ^ 1'(PAR_ODD) ^ inj_par_q;
      ST_STOP:   txd_nxt = ~inj_frm_q;
      default:   txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
      idx       <= '0;
      data_q    <= '0;
      inj_par_q <= 1'b0;
      inj_frm_q <= 1'b0;
    end else begin
      txd_q  <= txd_nxt;
      done_q <= done_nxt;
      idx    <= idx_nxt;
      if (accept) begin
        data_q    <= TX_DATA;
        inj_par_q <= INJ_PAR_ERR;
        inj_frm_q <= INJ_FRM_ERR;
      end
    end
  end

endmodule

// File: tb/tb_vs_uart_err_tx.sv
// Self-checking bench: an even-parity and an odd-parity instance share all
// inputs; a frame-level model predicts both lines every cycle.
module tb_vs_uart_err_tx;

  localparam int DIV = 10;
  localparam int FRAME_CYC = 11 * DIV;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       inj_par;
  logic       inj_frm;
  logic       rdy_e, done_e, txd_e;
  logic       rdy_o, done_o, txd_o;

  int n_cmp;
  int n_fail;

  vs_uart_err_tx #(.CLK_FREQ(1000), .BAUD(100), .PAR_ODD(0)) dut_e (
    .CLK(clk), .SYS_NRST(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid),
    .INJ_PAR_ERR(inj_par), .INJ_FRM_ERR(inj_frm),
    .TX_RDY(rdy_e), .TX_DONE(done_e), .TXD(txd_e)
  );

  vs_uart_err_tx #(.CLK_FREQ(1000), .BAUD(100), .PAR_ODD(1)) dut_o (
    .CLK(clk), .SYS_NRST(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid),
    .INJ_PAR_ERR(inj_par), .INJ_FRM_ERR(inj_frm),
    .TX_RDY(rdy_o), .TX_DONE(done_o), .TXD(txd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame in flight, and the cycle position inside it.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  int         m_pos  = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_ip   = 1'b0;
  logic       m_if   = 1'b0;

  function automatic logic model_txd(input logic odd);
    int b;
    if (!m_busy) return 1'b1;
    b = m_pos / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_data[b-1];
    if (b == 9) return (^m_data) ^ odd ^ m_ip;
    return !m_if;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_pos  = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_pos++;
        if (m_pos == FRAME_CYC) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (tx_valid) begin
        m_busy = 1'b1;
        m_pos  = 0;
        m_data = tx_data;
        m_ip   = inj_par;
        m_if   = inj_frm;
      end
    end
    #1;
    chk("txd_even", 32'(txd_e), 32'(model_txd(1'b0)));
    chk("txd_odd",  32'(txd_o), 32'(model_txd(1'b1)));
    chk("rdy_even", 32'(rdy_e), 32'(!m_busy));
    chk("rdy_odd",  32'(rdy_o), 32'(!m_busy));
    chk("done_even", 32'(done_e), 32'(m_done));
    chk("done_odd",  32'(done_o), 32'(m_done));
  end

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_e && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(rdy_e), 32'd1);
  endtask

  // Sends one byte and samples both lines mid-bit; vector bit b = frame bit b.
  task automatic send(input logic [7:0] d, input logic ip, input logic ifr,
                      output logic [10:0] ve, output logic [10:0] vo,
                      output int dcnt, output int dat, output logic post);
    ve = '0; vo = '0; dcnt = 0; dat = -1; post = 1'b0;
    wait_idle(300);
    tx_valid = 1'b1; tx_data = d; inj_par = ip; inj_frm = ifr;
    for (int j = 0; j <= FRAME_CYC + 5; j++) begin
      @(negedge clk);
      if (j % DIV == 5 && j < FRAME_CYC) begin
        ve[j/DIV] = txd_e;
        vo[j/DIV] = txd_o;
      end
      if (done_e) begin
        dcnt++;
        if (dat < 0) dat = j;
      end
      if (j == FRAME_CYC + 5) post = txd_e;
      if (j == 0) begin
        // Inputs change while the frame is in flight.
        tx_valid = 1'b0; tx_data = ~d; inj_par = ~ip; inj_frm = ~ifr;
      end
    end
    inj_par = 1'b0; inj_frm = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] ve, vo;
    int dcnt, dat, f1, f2, cyc;
    logic post, prev_rdy;

    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; inj_par = 1'b0; inj_frm = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd_e), 32'd1);
    chk("reset_rdy", 32'(rdy_e), 32'd1);
    chk("reset_done", 32'(done_e), 32'd0);
    rst_n = 1'b1;

    // 0x55, even: 0,1,0,1,0,1,0,1,0,0,1
    send(8'h55, 1'b0, 1'b0, ve, vo, dcnt, dat, post);
    chk("f55_even_bits", 32'(ve), 32'(11'b1_0_01010101_0));
    chk("f55_odd_bits",  32'(vo), 32'(11'b1_1_01010101_0));
    chk("f55_done_count", 32'(dcnt), 32'd1);
    chk("f55_done_cycle", 32'(dat), 32'd110);

    send(8'h01, 1'b1, 1'b0, ve, vo, dcnt, dat, post);
    chk("f01_injpar_even", 32'(ve), 32'(11'b1_0_00000001_0));
    chk("f01_injpar_odd",  32'(vo), 32'(11'b1_1_00000001_0));

    send(8'hA3, 1'b0, 1'b1, ve, vo, dcnt, dat, post);
    chk("fA3_injfrm_even", 32'(ve), 32'(11'b0_0_10100011_0));
    chk("fA3_injfrm_odd",  32'(vo), 32'(11'b0_1_10100011_0));
    chk("fA3_done_count", 32'(dcnt), 32'd1);
    chk("fA3_line_after", 32'(post), 32'd1);

    send(8'h00, 1'b0, 1'b0, ve, vo, dcnt, dat, post);
    chk("f00_odd_bits", 32'(vo), 32'(11'b1_1_00000000_0));
    send(8'hFF, 1'b0, 1'b0, ve, vo, dcnt, dat, post);
    chk("fFF_odd_bits", 32'(vo), 32'(11'b1_1_11111111_0));
    chk("fFF_even_bits", 32'(ve), 32'(11'b1_0_11111111_0));

    // Back-to-back with TX_VALID held high.
    wait_idle(300);
    tx_valid = 1'b1; tx_data = 8'h12;
    f1 = -1; f2 = -1; cyc = 0; prev_rdy = 1'b1;
    while (f2 < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_rdy && !rdy_e) begin
        if (f1 < 0) begin
          f1 = cyc; tx_data = 8'h34;
        end else begin
          f2 = cyc; tx_data = 8'h77; tx_valid = 1'b0;
        end
      end
      if (f1 >= 0 && f2 < 0 && cyc == f1 + 40) tx_data = 8'h34;
      if (f1 >= 0 && f2 < 0 && cyc == f1 + 20) tx_data = 8'hC9;
      prev_rdy = rdy_e;
    end
    tx_valid = 1'b0;
    chk("b2b_start_spacing", 32'(f2 - f1), 32'd111);

    // Reset during data bit 4 of 0xF0.
    wait_idle(300);
    tx_valid = 1'b1; tx_data = 8'hF0;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (53) @(negedge clk);
    chk("pre_reset_bit4", 32'(txd_e), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_txd_even", 32'(txd_e), 32'd1);
    chk("async_reset_txd_odd",  32'(txd_o), 32'd1);
    chk("async_reset_rdy", 32'(rdy_e), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_no_done", 32'(done_e | done_o), 32'd0);
    end
    rst_n = 1'b1;
    send(8'h0F, 1'b0, 1'b0, ve, vo, dcnt, dat, post);
    chk("f0F_even_bits", 32'(ve), 32'(11'b1_0_00001111_0));
    chk("f0F_odd_bits",  32'(vo), 32'(11'b1_1_00001111_0));
    chk("f0F_done_cycle", 32'(dat), 32'd110);

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      inj_par  = ($urandom_range(0, 3) == 0);
      inj_frm  = ($urandom_range(0, 3) == 0);
    end
    tx_valid = 1'b0; inj_par = 1'b0; inj_frm = 1'b0;
    wait_idle(300);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vs_uart_err_tx.md
VS_UART_ERR_TX -- requirements
Module: VS_UART_ERR_TX

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, using the port names CLK and SYS_NRST.
REQ-002 Parameter CLK_FREQ, default 100_000_000: clock frequency in Hz.
REQ-003 Parameter BAUD, default 115_200: line bit rate in bit/s.
REQ-004 Parameter PAR_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-005 CLK  input  1: system clock; all state updates on the rising edge.
REQ-006 SYS_NRST  input  1: asynchronous active-low reset.
REQ-007 TX_DATA  input  8: byte to transmit; sampled only on acceptance.
REQ-008 TX_VALID  input  1: request to send TX_DATA.
REQ-009 INJ_PAR_ERR  input  1: corrupt the parity bit of the accepted frame; sampled on acceptance.
REQ-010 INJ_FRM_ERR  input  1: corrupt the stop bit of the accepted frame; sampled on acceptance.
REQ-011 TX_RDY  output  1: high only in IDLE; the block can accept a byte.
REQ-012 TX_DONE  output  1: one-cycle pulse when a frame's stop bit completes.
REQ-013 TXD  output  1: serial line; idle level is 1.

Function
REQ-014 Bit period SHALL be DIV = (CLK_FREQ + BAUD/2) / BAUD clock cycles; DIV < 2 SHALL be rejected at elaboration.
REQ-015 Acceptance SHALL occur in a cycle with TX_VALID=1 and TX_RDY=1; TX_DATA, INJ_PAR_ERR and INJ_FRM_ERR are latched in that cycle.
REQ-016 Frame = start bit 0, then 8 data bits LSB first, then the parity bit, then the stop bit 1; 11 bits in total, each DIV cycles long.
REQ-017 Parity bit = XOR of the 8 data bits, XOR PAR_ODD, XOR the latched INJ_PAR_ERR.
REQ-018 The stop bit SHALL be 0 when the latched INJ_FRM_ERR=1; otherwise it SHALL be 1.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on acceptance.
- START -> DATA after DIV cycles.
- DATA -> PARITY after 8 bits, tracked by a 3-bit index that wraps 7->0.
- PARITY -> STOP after DIV cycles.
- STOP -> IDLE after DIV cycles.
REQ-020 TXD SHALL be registered; the start bit SHALL appear in the cycle after acceptance and last exactly DIV cycles.
REQ-021 TX_RDY SHALL drop in the cycle after acceptance and SHALL rise in the cycle after STOP ends, coincident with the TX_DONE pulse.
REQ-022 TX_VALID asserted outside IDLE SHALL be ignored, not queued.
REQ-023 Input changes after acceptance SHALL NOT alter the frame in flight.
REQ-024 Back-to-back transfer: with TX_VALID held high, consecutive start bits SHALL be exactly 11*DIV+1 cycles apart.
REQ-025 The baud counter SHALL restart at 0 on every acceptance, with no phase carried over from a previous frame.

Reset
REQ-026 On SYS_NRST=0, independent of CLK, the block SHALL force: state IDLE, TXD=1, TX_RDY=1 (derived from IDLE), TX_DONE=0, baud counter 0, bit index 0, latched data 0, inject flags 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately with TXD=1 and no TX_DONE pulse; the first acceptance after release SHALL send a complete frame.

Structure
REQ-028 State encoding, FRAME_BITS=11 and DATA_BITS=8 SHALL live in shared package VS_UART_PKG, for reuse by the receive side.
REQ-029 The bit-period counter SHALL be a sub-module VS_BAUD_GEN (inputs: restart and DIV; output: one-cycle bit-end strobe); the FSM and shifter SHALL be in VS_UART_ERR_TX.

Verification (CLK_FREQ=1000, BAUD=100, so DIV=10)
REQ-030 Send 0x55, even parity, no inject -> TXD = 0,1,0,1,0,1,0,1,0,0,1, each bit 10 cycles; TX_DONE pulses once, 110 cycles after the start bit begins.
REQ-031 Send 0x01 with INJ_PAR_ERR=1 -> parity bit 0 instead of 1; all other bits are unchanged.
REQ-032 Send 0xA3 with INJ_FRM_ERR=1 -> stop bit 0 for 10 cycles, TXD=1 afterwards, TX_DONE still pulses.
REQ-033 PAR_ODD=1, send 0x00 -> parity bit 1; then send 0xFF -> parity bit 1.
REQ-034 TX_VALID held high with 0x12 then 0x34 -> both frames are correct, start bits are 111 cycles apart, and TX_DATA changes mid-frame are ignored.
REQ-035 Assert SYS_NRST=0 during data bit 4 of 0xF0 -> TXD=1 without waiting for a clock edge, no TX_DONE; after release, 0x0F is sent as a correct frame.
